// File: rtl/ext_mem_arb_pkg.sv
// ext_mem_arb_pkg
// Shared definitions for the external memory arbiter:
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - requester port indices (PORT_D = data cache, PORT_I = instruction cache)
//   - default address and line widths
//   - helper turning a port index into a one-hot grant vector
package ext_mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PORT_D = 0;
  localparam int PORT_I = 1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ext_mem_rr_pick.sv
// ext_mem_rr_pick
// Combinational two-requester round-robin select.
// Ports:
//   req        in  2  request vector, bit PORT_D = data cache, bit PORT_I = instruction cache
//   last_grant in  1  index of the port that owned the previous transaction
//   grant      out 2  one-hot winner, 00 when nobody requests
module ext_mem_rr_pick
  import ext_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that did not win last time goes next.
      2'b11:   grant = (last_grant == 1'(PORT_I)) ? port_onehot(1'(PORT_D))
                                                  : port_onehot(1'(PORT_I));
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter
// Shares one external line-wide memory interface between the L1 data cache
// (port 0) and the L1 instruction cache (port 1). Requests are granted
// round-robin, the winning request is registered onto the external bus, and
// the read line is returned with a one-cycle ack. A watchdog aborts
// transactions the memory never acknowledges and raises a sticky error.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   p0_* / p1_*                    cache request ports (addr, cs, we, write line in,
//                                  read line out, one-cycle ack out)
//   mem_addr_o/cs_o/we_o/data_o    registered external request
//   mem_data_i, mem_ack_i          external read line and completion
//   grant_o                        one-hot owner of the current transaction
//   err_o                          sticky timeout flag
module ext_mem_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic              p0_cs_i,
  input  logic              p0_we_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_cs_i,
  input  logic              p1_we_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              last_grant_reg;
  logic [1:0]        grant_reg;
  logic [1:0]        pick;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_cs_reg;
  logic              mem_we_reg;
  logic [LINE_W-1:0] mem_data_reg;
  logic [LINE_W-1:0] p0_data_reg;
  logic [LINE_W-1:0] p1_data_reg;
  logic              p0_ack_reg;
  logic              p1_ack_reg;
  logic              err_reg;

  ext_mem_rr_pick u_pick (
    .req        ({p1_cs_i, p0_cs_i}),
    .last_grant (last_grant_reg),
    .grant      (pick)
  );

  assign cnt_next = cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'(PORT_I);
      grant_reg      <= 2'b00;
      mem_addr_reg   <= '0;
      mem_cs_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_data_reg   <= '0;
      p0_data_reg    <= '0;
      p1_data_reg    <= '0;
      p0_ack_reg     <= 1'b0;
      p1_ack_reg     <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the BUSY exit raises them.
      p0_ack_reg <= 1'b0;
      p1_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick != 2'b00) begin
            grant_reg      <= pick;
            last_grant_reg <= pick[PORT_I];
            mem_cs_reg     <= 1'b1;
            mem_addr_reg   <= pick[PORT_I] ? p1_addr_i : p0_addr_i;
            mem_we_reg     <= pick[PORT_I] ? p1_we_i   : p0_we_i;
            mem_data_reg   <= pick[PORT_I] ? p1_data_i : p0_data_i;
            cnt_reg        <= '0;
            state_reg      <= BUSY;
          end
        end
        BUSY: begin
          // The memory ack is checked first so it beats a same-cycle timeout.
          if (mem_ack_i) begin
            mem_cs_reg <= 1'b0;
            if (grant_reg[PORT_I]) begin
              p1_ack_reg <= 1'b1;
              if (!mem_we_reg) p1_data_reg <= mem_data_i;
            end else begin
              p0_ack_reg <= 1'b1;
              if (!mem_we_reg) p0_data_reg <= mem_data_i;
            end
            state_reg <= DONE;
          end else if (cnt_next == CNT_W'(TIMEOUT)) begin
            mem_cs_reg <= 1'b0;
            err_reg    <= 1'b1;
            if (grant_reg[PORT_I]) begin
              p1_ack_reg  <= 1'b1;
              p1_data_reg <= '0;
            end else begin
              p0_ack_reg  <= 1'b1;
              p0_data_reg <= '0;
            end
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        DONE: begin
          grant_reg <= 2'b00;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign p0_data_o  = p0_data_reg;
  assign p0_ack_o   = p0_ack_reg;
  assign p1_data_o  = p1_data_reg;
  assign p1_ack_o   = p1_ack_reg;
  assign mem_addr_o = mem_addr_reg;
  assign mem_cs_o   = mem_cs_reg;
  assign mem_we_o   = mem_we_reg;
  assign mem_data_o = mem_data_reg;
  assign grant_o    = grant_reg;
  assign err_o      = err_reg;

endmodule
